// File: rtl/adc_frontend_emu_if.sv
// Interface bundle between the DAQ readout and the ADC front-end emulator.
// The readout side (master) drives the strobes and the trigger enable.
// The emulator side (slave) drives the serial lanes, the trigger, busy and the error flags.
interface adc_frontend_emu_if #(
    parameter int unsigned NUM_LANES = 5
);
    logic                 sensor_clk;
    logic                 sensor_rst;
    logic                 adc_cnv;
    logic                 adc_clk;
    logic                 trg_en;
    logic [NUM_LANES-1:0] adc_data;
    logic                 trg_out;
    logic                 busy;
    logic [1:0]           err_sticky;

    modport master (
        output sensor_clk, sensor_rst, adc_cnv, adc_clk, trg_en,
        input  adc_data, trg_out, busy, err_sticky
    );

    modport slave (
        input  sensor_clk, sensor_rst, adc_cnv, adc_clk, trg_en,
        output adc_data, trg_out, busy, err_sticky
    );
endinterface

// File: rtl/adc_frontend_emu.sv
// Sensor-side emulator of the BPM front-end board.
// Responds to the readout strobes (sensor_clk, sensor_rst, adc_cnv, adc_clk) by
// serialising a known per-lane pattern on the ADC lanes, and generates a periodic
// external trigger. All strobes are asynchronous to clk and are synchronised here.
// Optional feature: define ADC_EMU_LFSR_EN to XOR LFSR noise into the low sample bits.
module adc_frontend_emu #(
    parameter int unsigned NUM_LANES    = 5,
    parameter int unsigned ADC_BITS     = 16,
    parameter int unsigned NUM_CHANNELS = 64,
    parameter int unsigned CONV_CYCLES  = 40,
    parameter int unsigned TRG_PERIOD   = 100000,
    parameter int unsigned TRG_WIDTH    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    adc_frontend_emu_if.slave bus
);
    localparam int unsigned CHW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned CW  = $clog2(CONV_CYCLES + 1);
    localparam int unsigned BW  = $clog2(ADC_BITS + 1);
    localparam int unsigned TW  = $clog2(TRG_PERIOD + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Strobe synchronisers: two flops, then a third flop holding the
    // previous synchronised level for edge detection.
    // Bit order of the 4-bit vectors: {adc_clk, adc_cnv, sensor_rst, sensor_clk}.
    // ------------------------------------------------------------------
    logic [3:0] pins_w;
    logic [3:0] sync1_q, sync2_q;
    logic [2:0] prev_q;   // {adc_clk, adc_cnv, sensor_clk}; sensor_rst is used as a level
    logic       sclk_rise_w, srst_lvl_w, cnv_rise_w, aclk_fall_w;

    assign pins_w = {bus.adc_clk, bus.adc_cnv, bus.sensor_rst, bus.sensor_clk};

    // Synchronise the asynchronous strobes and keep the previous level for edge detection.
    // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= pins_w;
            sync2_q <= sync1_q;
            prev_q  <= {sync2_q[3], sync2_q[2], sync2_q[0]};
        end
    end

    assign sclk_rise_w = sync2_q[0] & ~prev_q[0];
    assign srst_lvl_w  = sync2_q[1];
    assign cnv_rise_w  = sync2_q[2] & ~prev_q[1];
    assign aclk_fall_w = ~sync2_q[3] & prev_q[2];

    // ------------------------------------------------------------------
    // Channel / frame counters
    // ------------------------------------------------------------------
    logic [CHW-1:0] chan_q;
    logic [15:0]    frame_q;

    // Advance the channel on sensor_clk; sensor_rst holds it at zero and wins over sensor_clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chan_q  <= '0;
            frame_q <= '0;
        end else if (srst_lvl_w) begin
            chan_q  <= '0;
        end else if (sclk_rise_w) begin
            if (chan_q == CHW'(NUM_CHANNELS - 1)) begin
                chan_q  <= '0;
                frame_q <= frame_q + 16'd1;
            end else begin
                chan_q  <= chan_q + CHW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Conversion / serialisation FSM state
    // ------------------------------------------------------------------
    state_e                              state_q, state_d;
    logic [CW-1:0]                       conv_cnt_q, conv_cnt_d;
    logic [BW-1:0]                       bit_cnt_q, bit_cnt_d;
    logic [NUM_LANES-1:0][ADC_BITS-1:0]  shreg_q, shreg_d;
    logic [1:0]                          err_q, err_d;
    logic [NUM_LANES-1:0][ADC_BITS-1:0]  sample_w;

`ifdef ADC_EMU_LFSR_EN
    logic [15:0] lfsr_q;

    // Step the noise LFSR once per captured conversion (x^16+x^14+x^13+x^11+1).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else if (state_q == ST_CONV && conv_cnt_q == '0) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
`endif

    // Per-lane sample: lane index, channel and low frame bits packed into one word.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_sample
        logic [ADC_BITS-1:0] pattern;
        assign pattern = ADC_BITS'((32'(l) << 13)
                                 | ((32'(chan_q) & 32'h7F) << 6)
                                 | 32'(frame_q[5:0]));
`ifdef ADC_EMU_LFSR_EN
        assign sample_w[l] = pattern ^ ADC_BITS'(lfsr_q[3:0] ^ 4'(l));
`else
        assign sample_w[l] = pattern;
`endif
    end

    // Register the FSM state, counters, shift registers and sticky error flags.
    // NOTE: the shift registers are reset too because they feed adc_data directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            conv_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            conv_cnt_q <= conv_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: start conversion, count busy time, capture and shift, flag protocol errors.
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        err_d      = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cnv_rise_w) begin
                    state_d    = ST_CONV;
                    conv_cnt_d = CW'(CONV_CYCLES - 1);
                end
            end
            ST_CONV: begin
                if (aclk_fall_w) begin
                    err_d[0] = 1'b1;
                end
                if (conv_cnt_q == '0) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = sample_w;
                    bit_cnt_d = '0;
                end else begin
                    conv_cnt_d = conv_cnt_q - CW'(1);
                end
            end
            ST_SHIFT: begin
                if (cnv_rise_w) begin
                    // A new conversion request aborts the readout and restarts conversion.
                    err_d[1]   = 1'b1;
                    state_d    = ST_CONV;
                    conv_cnt_d = CW'(CONV_CYCLES - 1);
                    shreg_d    = '0;
                end else if (aclk_fall_w) begin
                    if (bit_cnt_q == BW'(ADC_BITS - 1)) begin
                        state_d = ST_IDLE;
                        shreg_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        for (int l = 0; l < int'(NUM_LANES); l++) begin
                            shreg_d[l] = shreg_q[l] << 1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                shreg_d = '0;
            end
        endcase
    end

    // Drive each lane with the MSB of its shift register while serialising.
    logic [NUM_LANES-1:0] adc_data_w;
    always_comb begin
        adc_data_w = '0;
        if (state_q == ST_SHIFT) begin
            for (int l = 0; l < int'(NUM_LANES); l++) begin
                adc_data_w[l] = shreg_q[l][ADC_BITS-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Periodic trigger
    // ------------------------------------------------------------------
    logic [TW-1:0] trg_cnt_q;
    logic          trg_q;

    // Free-running period counter while enabled; the pulse covers the first TRG_WIDTH counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trg_cnt_q <= '0;
            trg_q     <= 1'b0;
        end else if (!bus.trg_en) begin
            trg_cnt_q <= '0;
            trg_q     <= 1'b0;
        end else begin
            trg_q     <= (32'(trg_cnt_q) < TRG_WIDTH);
            trg_cnt_q <= (trg_cnt_q == TW'(TRG_PERIOD - 1)) ? '0 : trg_cnt_q + TW'(1);
        end
    end

    assign bus.adc_data   = adc_data_w;
    assign bus.trg_out    = trg_q;
    assign bus.busy       = (state_q == ST_CONV);
    assign bus.err_sticky = err_q;
endmodule

// File: tb/tb_adc_frontend_emu.sv
// Self-checking bench for adc_frontend_emu: randomised readout traffic with a
// queue-based scoreboard, plus directed error, reset and trigger scenarios.
module tb_adc_frontend_emu;
    localparam int LANES = 5;
    localparam int BITS  = 16;
    localparam int NCH   = 64;
    localparam int CONV  = 40;
    localparam int TP    = 20;
    localparam int TW    = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    adc_frontend_emu_if #(.NUM_LANES(LANES)) bus ();

    adc_frontend_emu #(
        .NUM_LANES   (LANES),
        .ADC_BITS    (BITS),
        .NUM_CHANNELS(NCH),
        .CONV_CYCLES (CONV),
        .TRG_PERIOD  (TP),
        .TRG_WIDTH   (TW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [LANES-1:0][15:0] w;
        int                     nbits;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model of the sensor state
    int          m_chan;
    int          m_frame;
    logic [15:0] m_lfsr;
    bit          m_rst_held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_model();
        m_chan     = 0;
        m_frame    = 0;
        m_lfsr     = 16'hACE1;
        m_rst_held = 1'b0;
    endtask

    function automatic logic [15:0] model_word(input int lane);
        int v;
        v = (lane * 8192 + m_chan * 64 + (m_frame % 64)) % 65536;
`ifdef ADC_EMU_LFSR_EN
        v = v ^ int'(m_lfsr[3:0] ^ lane[3:0]);
`endif
        return v[15:0];
    endfunction

    task automatic push_expected(input int nb);
        exp_t e;
        for (int l = 0; l < LANES; l++) e.w[l] = model_word(l);
        e.nbits = nb;
        sb.push_back(e);
`ifdef ADC_EMU_LFSR_EN
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
    endtask

    task automatic pulse_sclk(input int n);
        repeat (n) begin
            bus.sensor_clk = 1'b1;
            tick(4);
            bus.sensor_clk = 1'b0;
            tick(4);
            if (m_rst_held) m_chan = 0;
            else if (m_chan == NCH - 1) begin
                m_chan  = 0;
                m_frame = (m_frame + 1) % 65536;
            end else m_chan++;
        end
    endtask

    task automatic pulse_srst();
        bus.sensor_rst = 1'b1;
        tick(4);
        bus.sensor_rst = 1'b0;
        tick(4);
        m_chan = 0;
    endtask

    // Start a conversion, check cnv->busy latency and busy length; optionally toggle adc_clk in CONV.
    task automatic do_conv(input bit toggle);
        int cnt;
        bus.adc_cnv = 1'b1;
        cnt = 0;
        while (bus.busy !== 1'b1 && cnt < 20) begin
            tick(1);
            cnt++;
        end
        check("cnv_to_busy_latency", cnt, 3);
        check("adc_data_zero_in_conv", 32'(bus.adc_data), 0);
        bus.adc_cnv = 1'b0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 200) begin
            if (toggle && cnt < 24) bus.adc_clk = ((cnt / 6) % 2 == 0) ? 1'b1 : 1'b0;
            tick(1);
            cnt++;
        end
        check("busy_high_cycles", cnt, CONV);
    endtask

    task automatic readout(input int nb);
        repeat (nb) begin
            bus.adc_clk = 1'b1;
            tick(6);
            bus.adc_clk = 1'b0;
            tick(6);
        end
        if (nb == BITS) begin
            check("adc_data_zero_after_word", 32'(bus.adc_data), 0);
            check("busy_low_after_word", 32'(bus.busy), 0);
        end
    endtask

    task automatic full_readout(input bit toggle);
        push_expected(BITS);
        do_conv(toggle);
        readout(BITS);
    endtask

    // Monitor: collect bits on adc_clk rising edges after each conversion, compare with the scoreboard.
    initial begin : monitor
        logic [LANES-1:0][15:0] got;
        int                     nb;
        exp_t                   e;
        forever begin
            @(negedge bus.busy);
            if (reset_n !== 1'b1) continue;
            got = '0;
            nb  = 0;
            while (nb < BITS) begin
                @(posedge bus.adc_clk or posedge bus.busy or negedge reset_n);
                if (reset_n !== 1'b1 || bus.busy === 1'b1) break;
                for (int l = 0; l < LANES; l++) got[l] = {got[l][14:0], bus.adc_data[l]};
                nb++;
            end
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got a word with %0d bits but no expected entry", nb);
            end else begin
                e = sb.pop_front();
                check("word_bit_count", nb, e.nbits);
                for (int l = 0; l < LANES; l++)
                    check($sformatf("lane%0d_word", l), 32'(got[l]), 32'(e.w[l] >> (16 - e.nbits)));
            end
        end
    end

    initial begin : stimulus
        bus.sensor_clk = 1'b0;
        bus.sensor_rst = 1'b0;
        bus.adc_cnv    = 1'b0;
        bus.adc_clk    = 1'b0;
        bus.trg_en     = 1'b0;
        reset_model();
        tick(3);
        check("reset_adc_data", 32'(bus.adc_data), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_err", 32'(bus.err_sticky), 0);
        check("reset_trg", 32'(bus.trg_out), 0);
        reset_n = 1'b1;
        tick(2);

        // sensor_rst then readout at channel 0 (lane 2 = 4000)
        pulse_srst();
        full_readout(1'b0);
        // five channel advances (lane 0 = 0140, lane 4 = 8140)
        pulse_sclk(5);
        full_readout(1'b0);
        // complete the frame: chan wraps to 0, frame 1 (lane 1 = 2001)
        pulse_sclk(NCH - 5);
        full_readout(1'b0);

        // sensor_rst held high masks sensor_clk edges
        bus.sensor_rst = 1'b1;
        m_rst_held     = 1'b1;
        tick(4);
        pulse_sclk(3);
        bus.sensor_rst = 1'b0;
        m_rst_held     = 1'b0;
        tick(4);
        full_readout(1'b0);

        // randomised channel traffic and readouts
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0) pulse_srst();
            pulse_sclk($urandom_range(0, 70));
            full_readout(1'b0);
        end
        check("err_clean_before_fault_tests", 32'(bus.err_sticky), 0);

        // adc_clk activity during CONV: flagged, word still intact
        pulse_sclk($urandom_range(1, 10));
        full_readout(1'b1);
        check("err_adc_clk_in_conv", 32'(bus.err_sticky), 32'b01);

        // cnv after 7 bits: abort, restart, full word afterwards
        push_expected(7);
        do_conv(1'b0);
        readout(7);
        push_expected(BITS);
        do_conv(1'b0);
        check("err_cnv_in_shift", 32'(bus.err_sticky), 32'b11);
        readout(BITS);

        // reset in the middle of a readout
        pulse_sclk(2);
        push_expected(5);
        do_conv(1'b0);
        readout(5);
        reset_n = 1'b0;
        #1;
        check("midreset_adc_data", 32'(bus.adc_data), 0);
        check("midreset_busy", 32'(bus.busy), 0);
        check("midreset_err", 32'(bus.err_sticky), 0);
        reset_model();
        tick(2);
        reset_n = 1'b1;
        tick(2);
        pulse_sclk(3);
        full_readout(1'b0);
        check("err_after_reset", 32'(bus.err_sticky), 0);

        // trigger: TW high every TP cycles, first pulse one clock after enable
        bus.trg_en = 1'b1;
        for (int t = 1; t <= 82; t++) begin
            tick(1);
            check("trg_out_periodic", 32'(bus.trg_out), (((t - 1) % TP) < TW) ? 1 : 0);
        end
        bus.trg_en = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            tick(1);
            check("trg_out_cut", 32'(bus.trg_out), 0);
        end
        bus.trg_en = 1'b1;
        tick(1);
        check("trg_out_restart", 32'(bus.trg_out), 1);
        tick(3);
        check("trg_out_restart_end", 32'(bus.trg_out), 0);
        bus.trg_en = 1'b0;

        tick(20);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
